// File: rtl/capture_pkg.sv
// Shared types and helpers for the triggered analog probe capture block.
// Optional decimator is enabled with ANASYMOD_CAPTURE_DECIM_EN.
package capture_pkg;

    localparam int CAP_WIDTH = 25;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        POST,
        DONE,
        READOUT
    } cap_state_e;

    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/analog_probe_capture_if.sv
// Readout stream from the capture buffer to the host path.
// Part of analog_probe_capture (decimator macro: ANASYMOD_CAPTURE_DECIM_EN).
interface analog_probe_capture_if
    import capture_pkg::*;
#(
    parameter int WIDTH = CAP_WIDTH
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, registered read port.
// Used by analog_probe_capture (macro ANASYMOD_CAPTURE_DECIM_EN has no effect here).
module capture_ram
    import capture_pkg::*;
#(
    parameter int WIDTH = CAP_WIDTH,
    parameter int DEPTH = 256,
    localparam int AW   = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/analog_probe_capture.sv
// Triggered circular-buffer capture of one fixed-point signal, streamed oldest first.
// Define ANASYMOD_CAPTURE_DECIM_EN to add the strobe decimator and decim port.
module analog_probe_capture
    import capture_pkg::*;
#(
    parameter int WIDTH   = CAP_WIDTH,
    parameter int DEPTH   = 256,
    parameter int PRE     = 64,
    parameter int DECIM_W = 8
) (
    input  logic                    emu_clk,
    input  logic                    emu_rst,
    input  logic                    smp_en,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic signed [WIDTH-1:0] thresh,
    input  logic                    arm,
    input  logic                    abort,
`ifdef ANASYMOD_CAPTURE_DECIM_EN
    input  logic [DECIM_W-1:0]      decim,
`endif
    output logic                    busy,
    output logic                    triggered,
    output logic                    done,
    analog_probe_capture_if.master  rd
);
    localparam int AW = addr_w(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PRE_C   = CW'(PRE);
    localparam logic [CW-1:0] POST_M1 = CW'(DEPTH - PRE - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    cap_state_e state;

    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;
    logic [AW-1:0]           out_idx;
    logic [CW-1:0]           pre_cnt;
    logic [CW-1:0]           post_cnt;
    logic [CW-1:0]           iss_cnt;
    logic signed [WIDTH-1:0] thr;
    logic signed [WIDTH-1:0] prev;
    logic                    prev_ok;
    logic                    trig_q;
    logic                    rv;
    logic                    ov;
    logic                    ol;
    logic [WIDTH-1:0]        od;
    logic [WIDTH-1:0]        rdata;

    logic acc;
    logic capturing;
    logic we;
    logic trig;
    logic re;
    logic out_load;
    logic out_fire;
    logic fin;

`ifdef ANASYMOD_CAPTURE_DECIM_EN
    logic [DECIM_W-1:0] dcnt;
    assign acc = smp_en && (dcnt == '0);
`else
    wire [DECIM_W-1:0] unused_decim = '0;
    assign acc = smp_en;
`endif

    assign capturing = (state == ARMED) || (state == POST);
    assign we        = capturing && acc;

    // Rising crossing, only once the pre-trigger window is full
    assign trig = (state == ARMED) && acc && prev_ok &&
                  (pre_cnt == PRE_C) &&
                  (prev < thr) && (in_data >= thr);

    assign out_fire = ov && rd.out_ready;
    assign fin      = out_fire && ol;
    assign out_load = rv && (!ov || rd.out_ready);

    // Keep one sample staged behind the output register
    assign re = ((state == DONE) || (state == READOUT)) &&
                (iss_cnt != DEPTH_C) && (!rv || out_load);

    assign busy         = capturing;
    assign done         = (state == DONE) || (state == READOUT);
    assign triggered    = trig_q;
    assign rd.out_valid = ov;
    assign rd.out_data  = od;
    assign rd.out_last  = ol;

    capture_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (emu_clk),
        .we    (we),
        .waddr (wptr),
        .wdata (in_data),
        .re    (re),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge emu_clk) begin
        if (emu_rst || abort) begin
            state    <= IDLE;
            wptr     <= '0;
            rptr     <= '0;
            out_idx  <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            iss_cnt  <= '0;
            thr      <= '0;
            prev     <= '0;
            prev_ok  <= 1'b0;
            trig_q   <= 1'b0;
            rv       <= 1'b0;
            ov       <= 1'b0;
            ol       <= 1'b0;
            od       <= '0;
`ifdef ANASYMOD_CAPTURE_DECIM_EN
            dcnt     <= '0;
`endif
        end else begin
            if (we) wptr <= wptr + AW'(1);
`ifdef ANASYMOD_CAPTURE_DECIM_EN
            if (capturing && smp_en)
                dcnt <= (dcnt == '0) ? decim : dcnt - DECIM_W'(1);
`endif
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        state   <= ARMED;
                        thr     <= thresh;
                        wptr    <= '0;
                        pre_cnt <= '0;
                        prev_ok <= 1'b0;
                        trig_q  <= 1'b0;
`ifdef ANASYMOD_CAPTURE_DECIM_EN
                        dcnt    <= decim;
`endif
                    end
                end
                ARMED: begin
                    if (acc) begin
                        prev    <= in_data;
                        prev_ok <= 1'b1;
                        if (pre_cnt != PRE_C)
                            pre_cnt <= pre_cnt + CW'(1);
                        if (trig) begin
                            trig_q   <= 1'b1;
                            rptr     <= wptr - AW'(PRE);
                            post_cnt <= CW'(1);
                            iss_cnt  <= '0;
                            out_idx  <= '0;
                            state    <= (DEPTH - PRE == 1) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (acc) begin
                        post_cnt <= post_cnt + CW'(1);
                        if (post_cnt == POST_M1) state <= DONE;
                    end
                end
                DONE: state <= READOUT;
                READOUT: begin
                    if (fin) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (re) begin
                rv      <= 1'b1;
                rptr    <= rptr + AW'(1);
                iss_cnt <= iss_cnt + CW'(1);
            end else if (out_load) begin
                rv <= 1'b0;
            end
            if (out_load) begin
                od      <= rdata;
                ol      <= (out_idx == AW'(DEPTH - 1));
                out_idx <= out_idx + AW'(1);
            end
            if (fin) begin
                ov <= 1'b0;
                ol <= 1'b0;
            end else if (out_load) begin
                ov <= 1'b1;
            end else if (out_fire) begin
                ov <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_analog_probe_capture.sv
// Self-checking bench for analog_probe_capture against a sample-list model.
// Decimation scenario runs only with ANASYMOD_CAPTURE_DECIM_EN defined.
module tb_analog_probe_capture;
    localparam int W = 25;
    localparam int D = 256;
    localparam int P = 64;
    localparam int BUDGET = 4000;

    logic clk = 1'b0;
    logic rst;
    logic smp_en;
    logic arm;
    logic abort;
    logic signed [W-1:0] in_data;
    logic signed [W-1:0] thresh;
`ifdef ANASYMOD_CAPTURE_DECIM_EN
    logic [7:0] decim;
`endif
    logic busy;
    logic triggered;
    logic done;

    always #5 clk = ~clk;

    analog_probe_capture_if #(.WIDTH(W)) rd ();

    analog_probe_capture #(
        .WIDTH   (W),
        .DEPTH   (D),
        .PRE     (P),
        .DECIM_W (8)
    ) dut (
        .emu_clk   (clk),
        .emu_rst   (rst),
        .smp_en    (smp_en),
        .in_data   (in_data),
        .thresh    (thresh),
        .arm       (arm),
        .abort     (abort),
`ifdef ANASYMOD_CAPTURE_DECIM_EN
        .decim     (decim),
`endif
        .busy      (busy),
        .triggered (triggered),
        .done      (done),
        .rd        (rd.master)
    );

    int checks = 0;
    int errors = 0;

    int got[$];
    bit lastq[$];
    int accq[$];
    int expq[$];
    int first_done;
    int first_valid;
    int stall_bad;
    int bubbles;
    bit timed_out;
    int ramp_v;
    int ramp_step;

    // Reference: first rising crossing with a full pre-window, then DEPTH samples
    function automatic int find_trig(input int q[$], input int th);
        for (int i = P; i < q.size(); i++)
            if (q[i-1] < th && q[i] >= th) return i;
        return -1;
    endfunction

    task automatic build_expected(input int th);
        int t;
        expq.delete();
        t = find_trig(accq, th);
        if (t >= 0)
            for (int i = 0; i < D && (t - P + i) < accq.size(); i++)
                expq.push_back(accq[t - P + i]);
    endtask

    function automatic int diff_count();
        int n;
        n = (got.size() > expq.size()) ? got.size() - expq.size()
                                       : expq.size() - got.size();
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            if (got[i] != expq[i]) n++;
        return n;
    endfunction

    function automatic int last_pos();
        for (int i = 0; i < lastq.size(); i++)
            if (lastq[i]) return i;
        return -1;
    endfunction

    function automatic int last_count();
        int n;
        n = 0;
        foreach (lastq[i]) if (lastq[i]) n++;
        return n;
    endfunction

    task automatic ramp_tick(input bit en);
        smp_en  = en;
        in_data = W'(ramp_v);
        if (en) ramp_v += ramp_step;
        @(negedge clk);
    endtask

    task automatic run_capture(input int start, input int step,
                               input int th, input int en_pct,
                               input int rdy_mode, input int dec);
        int k;
        bit pv, pr, pl, rdy, en, fin;
        logic [W-1:0] pd;
        got.delete();
        lastq.delete();
        accq.delete();
        first_done  = -1;
        first_valid = -1;
        stall_bad   = 0;
        bubbles     = 0;
        timed_out   = 1'b0;
        @(negedge clk);
        thresh = W'(th);
        smp_en = 1'b0;
        arm    = 1'b1;
`ifdef ANASYMOD_CAPTURE_DECIM_EN
        decim  = 8'(dec);
`endif
        @(negedge clk);
        arm = 1'b0;
        k   = 0;
        pv  = 1'b0;
        pr  = 1'b0;
        pl  = 1'b0;
        pd  = '0;
        fin = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
            if (done && first_done < 0) first_done = cyc;
            if (rd.out_valid && first_valid < 0) first_valid = cyc;
            if (pv && !pr &&
                (!rd.out_valid || rd.out_data !== pd || rd.out_last !== pl))
                stall_bad++;
            if (pv && pr && !pl && !rd.out_valid) bubbles++;
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rd.out_ready = rdy;
            if (rd.out_valid && rdy) begin
                got.push_back(int'($signed(rd.out_data)));
                lastq.push_back(rd.out_last);
                if (rd.out_last) fin = 1'b1;
            end
            pv = rd.out_valid;
            pr = rdy;
            pd = rd.out_data;
            pl = rd.out_last;
            en = ($urandom_range(1, 100) <= en_pct);
            smp_en  = en;
            in_data = W'(start + step * k);
            if (en) begin
                if (k % (dec + 1) == dec) accq.push_back(start + step * k);
                k++;
            end
            @(negedge clk);
        end
        rd.out_ready = 1'b0;
        smp_en = 1'b0;
        if (!fin) timed_out = 1'b1;
        build_expected(th);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || triggered !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b trig=%b done=%b want 000",
                     busy, triggered, done);
        end
        checks++;
        if (rd.out_valid !== 1'b0 || rd.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: valid=%b last=%b want 00",
                     rd.out_valid, rd.out_last);
        end
        checks++;
        if (rd.out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %0h want 0", rd.out_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        run_capture(-100, 1, 0, 100, 0, 0);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL ramp_timeout: got %0d samples want %0d", got.size(), D);
        end
        checks++;
        if (diff_count() != 0) begin
            errors++;
            $display("FAIL ramp_stream: %0d diffs, got size %0d want %0d",
                     diff_count(), got.size(), expq.size());
        end
        checks++;
        if (got.size() != D || got[0] != -64 || got[D-1] != 191) begin
            errors++;
            $display("FAIL ramp_ends: size %0d first %0d last %0d want %0d -64 191",
                     got.size(), got.size() ? got[0] : 0,
                     got.size() ? got[got.size()-1] : 0, D);
        end
        checks++;
        if (last_pos() != D - 1 || last_count() != 1) begin
            errors++;
            $display("FAIL ramp_last: pos %0d count %0d want %0d 1",
                     last_pos(), last_count(), D - 1);
        end
        checks++;
        if (first_valid - first_done != 2) begin
            errors++;
            $display("FAIL ramp_latency: %0d cycles want 2",
                     first_valid - first_done);
        end
        checks++;
        if (bubbles != 0) begin
            errors++;
            $display("FAIL ramp_bubbles: got %0d want 0", bubbles);
        end
        checks++;
        if (rd.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ramp_idle: valid=%b done=%b busy=%b want 000",
                     rd.out_valid, done, busy);
        end
    endtask

    task automatic test_no_pretrig();
        int bad;
        bit model_trig;
        bad = 0;
        accq.delete();
        @(negedge clk);
        thresh = '0;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        ramp_v = -10;
        ramp_step = 1;
        for (int i = 0; i < 400; i++) begin
            accq.push_back(ramp_v);
            ramp_tick(1'b1);
            model_trig = (find_trig(accq, 0) >= 0);
            if (busy !== !model_trig || triggered !== model_trig) bad++;
        end
        smp_en = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_pretrig: %0d bad cycles, busy=%b trig=%b want 1 0",
                     bad, busy, triggered);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || triggered !== 1'b0) begin
            errors++;
            $display("FAIL no_pretrig_abort: busy=%b trig=%b want 00",
                     busy, triggered);
        end
    endtask

    task automatic test_stall();
        run_capture(-100, 1, 0, 100, 1, 0);
        checks++;
        if (timed_out || diff_count() != 0) begin
            errors++;
            $display("FAIL stall_stream: timeout=%b diffs %0d size %0d want 0 0 %0d",
                     timed_out, diff_count(), got.size(), D);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d unstable cycles want 0", stall_bad);
        end
        checks++;
        if (last_pos() != D - 1 || last_count() != 1) begin
            errors++;
            $display("FAIL stall_last: pos %0d count %0d want %0d 1",
                     last_pos(), last_count(), D - 1);
        end
    endtask

    task automatic test_abort_post();
        int n;
        @(negedge clk);
        thresh = '0;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        ramp_v = -100;
        ramp_step = 1;
        n = 0;
        while (!triggered && n < 1000) begin
            ramp_tick(1'b1);
            n++;
        end
        repeat (20) ramp_tick(1'b1);
        checks++;
        if (triggered !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_post: trig=%b busy=%b done=%b want 110",
                     triggered, busy, done);
        end
        abort = 1'b1;
        ramp_tick(1'b1);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || triggered !== 1'b0 ||
            done !== 1'b0 || rd.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b trig=%b done=%b valid=%b want 0000",
                     busy, triggered, done, rd.out_valid);
        end
        smp_en = 1'b0;
        run_capture(-100, 1, 0, 100, 0, 0);
        checks++;
        if (timed_out || diff_count() != 0) begin
            errors++;
            $display("FAIL abort_rearm: timeout=%b diffs %0d size %0d want 0 0 %0d",
                     timed_out, diff_count(), got.size(), D);
        end
    endtask

    task automatic test_arm_abort_and_reset();
        int bad, n;
        bad = 0;
        @(negedge clk);
        thresh = '0;
        arm = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        abort = 1'b0;
        ramp_v = -100;
        ramp_step = 1;
        for (int i = 0; i < 150; i++) begin
            ramp_tick(1'b1);
            if (busy !== 1'b0 || triggered !== 1'b0) bad++;
        end
        smp_en = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL arm_abort: %0d cycles busy/trig set, want 0", bad);
        end
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        ramp_v = -100;
        n = 0;
        while (!rd.out_valid && n < 1000) begin
            ramp_tick(1'b1);
            n++;
        end
        smp_en = 1'b0;
        checks++;
        if (rd.out_valid !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL readout_reached: valid=%b done=%b want 11",
                     rd.out_valid, done);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rd.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
            triggered !== 1'b0 || rd.out_last !== 1'b0 || rd.out_data !== '0) begin
            errors++;
            $display("FAIL reset_readout: valid=%b done=%b busy=%b trig=%b last=%b data=%0h want all 0",
                     rd.out_valid, done, busy, triggered, rd.out_last, rd.out_data);
        end
    endtask

`ifdef ANASYMOD_CAPTURE_DECIM_EN
    task automatic test_decim();
        run_capture(-400, 1, 0, 100, 0, 3);
        checks++;
        if (timed_out || diff_count() != 0) begin
            errors++;
            $display("FAIL decim_stream: timeout=%b diffs %0d size %0d want 0 0 %0d",
                     timed_out, diff_count(), got.size(), D);
        end
        checks++;
        if (got.size() != D || got[P] != 3 || got[1] - got[0] != 4) begin
            errors++;
            $display("FAIL decim_step: size %0d trig %0d step %0d want %0d 3 4",
                     got.size(), got.size() > P ? got[P] : 0,
                     got.size() > 1 ? got[1] - got[0] : 0, D);
        end
    endtask
`endif

    task automatic test_random();
        int step, th, start, en_pct;
        for (int it = 0; it < 4; it++) begin
            step   = int'($urandom_range(1, 3));
            th     = int'($urandom_range(0, 40)) - 20;
            start  = th - step * int'($urandom_range(P + 1, P + 150));
            en_pct = int'($urandom_range(40, 100));
            run_capture(start, step, th, en_pct, 2, 0);
            checks++;
            if (timed_out || diff_count() != 0) begin
                errors++;
                $display("FAIL random_%0d_stream: timeout=%b diffs %0d size %0d want 0 0 %0d",
                         it, timed_out, diff_count(), got.size(), D);
            end
            checks++;
            if (stall_bad != 0 || last_pos() != D - 1) begin
                errors++;
                $display("FAIL random_%0d_hold: unstable %0d last pos %0d want 0 %0d",
                         it, stall_bad, last_pos(), D - 1);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        smp_en       = 1'b0;
        arm          = 1'b0;
        abort        = 1'b0;
        in_data      = '0;
        thresh       = '0;
        rd.out_ready = 1'b0;
`ifdef ANASYMOD_CAPTURE_DECIM_EN
        decim        = 8'd0;
`endif
        test_reset();
        test_ramp();
        test_no_pretrig();
        test_stall();
        test_abort_post();
        test_arm_abort_and_reset();
`ifdef ANASYMOD_CAPTURE_DECIM_EN
        test_decim();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
